// File: rtl/core_writeback_stage_if.sv
// Execute, load-issue, memory-response and register-file write signals
// exchanged between the pipeline and the writeback stage.
interface core_writeback_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_WIDTH_CODE = 3
);
    logic                      ex_valid;
    logic                      ex_rd_use;
    logic [4:0]                ex_rd_addr;
    logic [DATA_WIDTH-1:0]     ex_result;
    logic                      ex_ready;
    logic                      ld_issue_valid;
    logic [4:0]                ld_issue_rd_addr;
    logic [MEM_WIDTH_CODE-1:0] ld_issue_control;
    logic [1:0]                ld_issue_offset;
    logic                      ld_issue_ready;
    logic                      mem_rvalid;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      mem_rready;
    logic                      rf_we;
    logic [4:0]                rf_addr;
    logic [DATA_WIDTH-1:0]     rf_data;
    logic                      lq_empty;

    modport master (
        output ex_valid, ex_rd_use, ex_rd_addr, ex_result,
        output ld_issue_valid, ld_issue_rd_addr, ld_issue_control, ld_issue_offset,
        output mem_rvalid, mem_rdata,
        input  ex_ready, ld_issue_ready, mem_rready,
        input  rf_we, rf_addr, rf_data, lq_empty
    );

    modport slave (
        input  ex_valid, ex_rd_use, ex_rd_addr, ex_result,
        input  ld_issue_valid, ld_issue_rd_addr, ld_issue_control, ld_issue_offset,
        input  mem_rvalid, mem_rdata,
        output ex_ready, ld_issue_ready, mem_rready,
        output rf_we, rf_addr, rf_data, lq_empty
    );
endinterface

// File: rtl/core_writeback_stage.sv
// Writeback stage: in-order load queue plus load/execute arbitration onto a
// single registered register-file write port. Load responses win over execute.
module core_writeback_stage #(
    parameter int LQ_DEPTH       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_WIDTH_CODE = 3
) (
    input logic                   clk,
    input logic                   arst_n,
    core_writeback_stage_if.slave wb
);
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(LQ_DEPTH);

    // Load type codes (funct3 encoding)
    localparam logic [MEM_WIDTH_CODE-1:0] LB  = MEM_WIDTH_CODE'(0);
    localparam logic [MEM_WIDTH_CODE-1:0] LH  = MEM_WIDTH_CODE'(1);
    localparam logic [MEM_WIDTH_CODE-1:0] LW  = MEM_WIDTH_CODE'(2);
    localparam logic [MEM_WIDTH_CODE-1:0] LBU = MEM_WIDTH_CODE'(4);
    localparam logic [MEM_WIDTH_CODE-1:0] LHU = MEM_WIDTH_CODE'(5);

    logic [4:0]                lq_rd   [LQ_DEPTH];
    logic [MEM_WIDTH_CODE-1:0] lq_ctrl [LQ_DEPTH];
    logic [1:0]                lq_off  [LQ_DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [PTR_W:0]            count;
    logic                      lq_empty, push, pop, ex_acc;

    logic                  upd_p0, we_p0;
    logic [4:0]            addr_p0;
    logic [DATA_WIDTH-1:0] data_p0;
    logic                  rf_we_p1;
    logic [4:0]            rf_addr_p1;
    logic [DATA_WIDTH-1:0] rf_data_p1;

    function automatic logic [DATA_WIDTH-1:0] format_load(
        input logic [MEM_WIDTH_CODE-1:0] ctrl,
        input logic [1:0]                off,
        input logic [DATA_WIDTH-1:0]     word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (ctrl)
            LB:      format_load = {{(DATA_WIDTH - 8){b[7]}}, b};
            LBU:     format_load = {{(DATA_WIDTH - 8){1'b0}}, b};
            LH:      format_load = {{(DATA_WIDTH - 16){h[15]}}, h};
            LHU:     format_load = {{(DATA_WIDTH - 16){1'b0}}, h};
            LW:      format_load = word;
            default: format_load = '0;
        endcase
    endfunction

    assign lq_empty          = (count == '0);
    assign wb.lq_empty       = lq_empty;
    assign wb.ld_issue_ready = (count < DEPTH_C);
    assign wb.mem_rready     = !lq_empty;
    assign wb.ex_ready       = !(wb.mem_rvalid && !lq_empty);

    assign push   = wb.ld_issue_valid && wb.ld_issue_ready;
    assign pop    = wb.mem_rvalid && !lq_empty;
    assign ex_acc = wb.ex_valid && wb.ex_ready;

    // Stage p0: select the winning source and format load data
    always_comb begin
        upd_p0  = 1'b0;
        we_p0   = 1'b0;
        addr_p0 = wb.ex_rd_addr;
        data_p0 = wb.ex_result;
        if (pop) begin
            upd_p0  = 1'b1;
            addr_p0 = lq_rd[rd_ptr];
            data_p0 = format_load(lq_ctrl[rd_ptr], lq_off[rd_ptr], wb.mem_rdata);
            we_p0   = (lq_rd[rd_ptr] != 5'd0);
        end else if (ex_acc) begin
            upd_p0  = 1'b1;
            we_p0   = wb.ex_rd_use && (wb.ex_rd_addr != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd[wr_ptr]   <= wb.ld_issue_rd_addr;
            lq_ctrl[wr_ptr] <= wb.ld_issue_control;
            lq_off[wr_ptr]  <= wb.ld_issue_offset;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Stage p1: registered write port; address/data hold when nothing is accepted
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rf_we_p1   <= 1'b0;
            rf_addr_p1 <= '0;
            rf_data_p1 <= '0;
        end else begin
            rf_we_p1 <= we_p0;
            if (upd_p0) begin
                rf_addr_p1 <= addr_p0;
                rf_data_p1 <= data_p0;
            end
        end
    end

    assign wb.rf_we   = rf_we_p1;
    assign wb.rf_addr = rf_addr_p1;
    assign wb.rf_data = rf_data_p1;
endmodule

// File: tb/tb_core_writeback_stage.sv
// Directed bench for core_writeback_stage: reset, execute writes, load
// extension, queue full, arbitration conflict, spurious responses.
module tb_core_writeback_stage;
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
    localparam logic [31:0] RDATA = 32'h80F0_7F81;

    logic clk;
    logic arst_n;
    int   checks;
    int   errors;

    core_writeback_stage_if #(.DATA_WIDTH(32), .MEM_WIDTH_CODE(3)) wb ();

    core_writeback_stage #(.LQ_DEPTH(4), .DATA_WIDTH(32), .MEM_WIDTH_CODE(3)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .wb     (wb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] ctrl, input logic [1:0] off);
        wb.ld_issue_valid   = 1'b1;
        wb.ld_issue_rd_addr = rd;
        wb.ld_issue_control = ctrl;
        wb.ld_issue_offset  = off;
    endtask

    task automatic ex_drive(input logic [4:0] rd, input logic [31:0] res);
        wb.ex_valid   = 1'b1;
        wb.ex_rd_use  = 1'b1;
        wb.ex_rd_addr = rd;
        wb.ex_result  = res;
    endtask

    task automatic expect_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
        check({tag, "_we"}, 32'(wb.rf_we), 32'd1);
        check({tag, "_addr"}, 32'(wb.rf_addr), 32'(rd));
        check({tag, "_data"}, wb.rf_data, data);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        arst_n = 1'b0;
        wb.ex_valid = 1'b0; wb.ex_rd_use = 1'b0; wb.ex_rd_addr = '0; wb.ex_result = '0;
        wb.ld_issue_valid = 1'b0; wb.ld_issue_rd_addr = '0; wb.ld_issue_control = '0;
        wb.ld_issue_offset = '0; wb.mem_rvalid = 1'b0; wb.mem_rdata = RDATA;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        check("rst_we", 32'(wb.rf_we), 32'd0);
        check("rst_addr", 32'(wb.rf_addr), 32'd0);
        check("rst_data", wb.rf_data, 32'd0);
        check("rst_empty", 32'(wb.lq_empty), 32'd1);
        check("rst_issue_ready", 32'(wb.ld_issue_ready), 32'd1);

        // Execute writes, including the x0 suppression and the hold behaviour
        ex_drive(5'd5, 32'hDEAD_BEEF);
        #1 check("alu_ex_ready", 32'(wb.ex_ready), 32'd1);
        tick();
        expect_write("alu", 5'd5, 32'hDEAD_BEEF);
        wb.ex_rd_addr = 5'd0;
        tick();
        check("alu_x0_we", 32'(wb.rf_we), 32'd0);
        wb.ex_valid = 1'b0;
        tick();
        check("idle_we", 32'(wb.rf_we), 32'd0);
        check("idle_hold_data", wb.rf_data, 32'hDEAD_BEEF);

        // Fill the queue
        issue(5'd1, LB, 2'd0);  tick();
        issue(5'd2, LBU, 2'd2); tick();
        issue(5'd3, LH, 2'd2);  tick();
        issue(5'd4, LHU, 2'd0); tick();
        check("full_issue_ready", 32'(wb.ld_issue_ready), 32'd0);
        check("full_not_empty", 32'(wb.lq_empty), 32'd0);
        issue(5'd9, LW, 2'd0);  tick();
        check("full_reject_we", 32'(wb.rf_we), 32'd0);

        // Response while full with a simultaneous issue: issue is not accepted
        wb.mem_rvalid = 1'b1;
        #1 check("resp_rready", 32'(wb.mem_rready), 32'd1);
        check("resp_ex_blocked", 32'(wb.ex_ready), 32'd0);
        tick();
        expect_write("lb_off0", 5'd1, 32'hFFFF_FF81);
        check("after_pop_ready", 32'(wb.ld_issue_ready), 32'd1);

        // Push and pop in the same cycle with room: count stays at 3
        issue(5'd5, LW, 2'd0);
        tick();
        expect_write("lbu_off2", 5'd2, 32'h0000_00F0);
        check("pushpop_ready", 32'(wb.ld_issue_ready), 32'd1);
        wb.mem_rvalid = 1'b0;
        issue(5'd11, LW, 2'd3);
        tick();
        wb.ld_issue_valid = 1'b0;
        #1 check("refull_ready", 32'(wb.ld_issue_ready), 32'd0);

        wb.mem_rvalid = 1'b1;
        tick(); expect_write("lh_off2", 5'd3, 32'hFFFF_80F0);
        tick(); expect_write("lhu_off0", 5'd4, 32'h0000_7F81);
        tick(); expect_write("lw_a", 5'd5, 32'h80F0_7F81);
        tick(); expect_write("lw_b", 5'd11, 32'h80F0_7F81);
        check("drained_empty", 32'(wb.lq_empty), 32'd1);

        // Spurious response with an empty queue
        #1 check("spur_rready", 32'(wb.mem_rready), 32'd0);
        check("spur_ex_ready", 32'(wb.ex_ready), 32'd1);
        tick();
        check("spur_we", 32'(wb.rf_we), 32'd0);
        check("spur_empty", 32'(wb.lq_empty), 32'd1);
        wb.mem_rvalid = 1'b0;

        // Load/execute conflict: load first, held execute result next
        issue(5'd7, LBU, 2'd1);
        tick();
        wb.ld_issue_valid = 1'b0;
        wb.mem_rvalid = 1'b1;
        ex_drive(5'd8, 32'h1234_5678);
        #1 check("conf_ex_ready", 32'(wb.ex_ready), 32'd0);
        tick();
        expect_write("conf_load", 5'd7, 32'h0000_007F);
        wb.mem_rvalid = 1'b0;
        #1 check("conf_ex_ready2", 32'(wb.ex_ready), 32'd1);
        tick();
        expect_write("conf_ex", 5'd8, 32'h1234_5678);
        wb.ex_valid = 1'b0;

        // Load to x0 pops without writing; unknown load code writes zero
        issue(5'd0, LW, 2'd0);  tick();
        issue(5'd10, 3'd3, 2'd0); tick();
        wb.ld_issue_valid = 1'b0;
        wb.mem_rvalid = 1'b1;
        tick();
        check("ld_x0_we", 32'(wb.rf_we), 32'd0);
        tick();
        expect_write("ld_badcode", 5'd10, 32'd0);
        wb.mem_rvalid = 1'b0;
        #1 check("x0_popped_empty", 32'(wb.lq_empty), 32'd1);

        // Asynchronous reset in the middle of a cycle with a queued load
        issue(5'd12, LW, 2'd0);
        tick();
        wb.ld_issue_valid = 1'b0;
        ex_drive(5'd13, 32'hCAFE_F00D);
        tick();
        expect_write("pre_rst", 5'd13, 32'hCAFE_F00D);
        wb.ex_valid = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        check("arst_we", 32'(wb.rf_we), 32'd0);
        check("arst_addr", 32'(wb.rf_addr), 32'd0);
        check("arst_data", wb.rf_data, 32'd0);
        check("arst_empty", 32'(wb.lq_empty), 32'd1);
        check("arst_issue_ready", 32'(wb.ld_issue_ready), 32'd1);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        wb.mem_rvalid = 1'b1;
        #1 check("post_rst_rready", 32'(wb.mem_rready), 32'd0);
        tick();
        check("post_rst_we", 32'(wb.rf_we), 32'd0);
        wb.mem_rvalid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
